// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier datapath: clears/loads, steps the
// shift/accumulate loop until the multiplier empties or the cap is hit, then
// holds a four-phase start/done handshake.
module mult_seq_ctrl #(
   parameter int ITER_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             zero_flag_i,
   input  logic             b0_i,
   output logic             load_o,
   output logic             prod_clr_o,
   output logic             enable_o,
   output logic             psel_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] iter_cnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER_MAX - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] iterCnt_q, iterCnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         iterCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         iterCnt_q <= iterCnt_d;
      end
   end

   // Abort wins over every transition and suppresses all datapath strobes.
   always_comb begin
      state_d   = state_q;
      iterCnt_d = iterCnt_q;
      enable_o  = 1'b0;
      psel_o    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i && !abort_i) state_d = LOAD;
         end
         LOAD: begin
            iterCnt_d = '0;
            state_d   = abort_i ? IDLE : RUN;
         end
         RUN: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (zero_flag_i) begin
               state_d = DONE;
            end else begin
               enable_o  = 1'b1;
               psel_o    = b0_i;
               iterCnt_d = iterCnt_q + 1'b1;
               if (iterCnt_q == LastIter) state_d = DONE;
            end
         end
         DONE: begin
            if (abort_i || !start_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign load_o     = (state_q == LOAD) && !abort_i;
   assign prod_clr_o = (state_q == LOAD) && !abort_i;
   assign busy_o     = (state_q == LOAD) || (state_q == RUN);
   assign done_o     = (state_q == DONE);
   assign iter_cnt_o = iterCnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Table-driven bench for mult_seq_ctrl with a behavioural model of the
// 8-bit multiplier shift register feeding zero_flag and b0.
module tb_mult_seq_ctrl;

   localparam int IterMax = 8;
   localparam int CntW    = 4;

   logic            clk = 1'b0;
   logic            rstN;
   logic            start;
   logic            abort;
   logic            zeroFlag;
   logic            b0;
   logic            load;
   logic            prodClr;
   logic            enable;
   logic            psel;
   logic            busy;
   logic            done;
   logic [CntW-1:0] iterCnt;

   logic [7:0]      operand = 8'd0;
   logic            forceMode = 1'b0;
   logic [7:0]      shiftReg = 8'd0;
   logic [9:0]      outVec;

   int checks = 0;
   int passes = 0;

   typedef struct {
      bit         start;
      bit         abort;
      logic [7:0] op;
      bit         frc;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   mult_seq_ctrl #(.ITER_MAX(IterMax), .CNT_W(CntW)) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .start_i     (start),
      .abort_i     (abort),
      .zero_flag_i (zeroFlag),
      .b0_i        (b0),
      .load_o      (load),
      .prod_clr_o  (prodClr),
      .enable_o    (enable),
      .psel_o      (psel),
      .busy_o      (busy),
      .done_o      (done),
      .iter_cnt_o  (iterCnt)
   );

   always #5 clk = ~clk;

   // Datapath model: operand latched on load, shifted right on each step.
   always @(posedge clk) begin
      if (load) shiftReg <= operand;
      else if (enable) shiftReg <= shiftReg >> 1;
   end

   assign zeroFlag = forceMode ? 1'b0 : (shiftReg == 8'd0);
   assign b0       = forceMode ? 1'b1 : shiftReg[0];
   assign outVec   = {load, prodClr, enable, psel, busy, done, iterCnt};

   task automatic addRow(input bit s, input bit a, input logic [7:0] op, input bit f,
                         input bit l, input bit c, input bit e, input bit p,
                         input bit b, input bit d, input int cnt);
      vec_t v;
      v.start = s;
      v.abort = a;
      v.op    = op;
      v.frc   = f;
      v.exp   = {l, c, e, p, b, d, 4'(cnt)};
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      start     = v.start;
      abort     = v.abort;
      operand   = v.op;
      forceMode = v.frc;
   endtask

   task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got {ld,clr,en,ps,busy,done,cnt}=%b required %b", name, act, exp);
   endtask

   initial begin
      // Vector fields: start abort op frc | load clr en psel busy done cnt
      // Operand 5: three steps, early exit, then DONE held with start high.
      addRow(1,0,8'd5,0, 0,0,0,0,0,0,0);
      addRow(1,0,8'd5,0, 1,1,0,0,1,0,0);
      addRow(1,0,8'd5,0, 0,0,1,1,1,0,0);
      addRow(1,0,8'd5,0, 0,0,1,0,1,0,1);
      addRow(1,0,8'd5,0, 0,0,1,1,1,0,2);
      addRow(1,0,8'd5,0, 0,0,0,0,1,0,3);
      for (int k = 0; k < 6; k++) addRow(1,0,8'd5,0, 0,0,0,0,0,1,3);
      addRow(0,0,8'd5,0, 0,0,0,0,0,1,3);
      addRow(0,0,8'd5,0, 0,0,0,0,0,0,3);
      // Zero multiplier.
      addRow(1,0,8'd0,0, 0,0,0,0,0,0,3);
      addRow(1,0,8'd0,0, 1,1,0,0,1,0,3);
      addRow(1,0,8'd0,0, 0,0,0,0,1,0,0);
      addRow(0,0,8'd0,0, 0,0,0,0,0,1,0);
      addRow(0,0,8'd0,0, 0,0,0,0,0,0,0);
      // Multiplier never empties: iteration cap.
      addRow(1,0,8'd5,1, 0,0,0,0,0,0,0);
      addRow(1,0,8'd5,1, 1,1,0,0,1,0,0);
      for (int k = 0; k < IterMax; k++) addRow(1,0,8'd5,1, 0,0,1,1,1,0,k);
      addRow(0,0,8'd5,1, 0,0,0,0,0,1,8);
      addRow(0,0,8'd5,0, 0,0,0,0,0,0,8);
      // Abort on the second RUN cycle, then a normal run with operand 6.
      addRow(1,0,8'd5,0, 0,0,0,0,0,0,8);
      addRow(1,0,8'd5,0, 1,1,0,0,1,0,8);
      addRow(1,0,8'd5,0, 0,0,1,1,1,0,0);
      addRow(1,1,8'd5,0, 0,0,0,0,1,0,1);
      addRow(1,0,8'd6,0, 0,0,0,0,0,0,1);
      addRow(1,0,8'd6,0, 1,1,0,0,1,0,1);
      addRow(1,0,8'd6,0, 0,0,1,0,1,0,0);
      addRow(1,0,8'd6,0, 0,0,1,1,1,0,1);
      addRow(1,0,8'd6,0, 0,0,1,1,1,0,2);
      addRow(1,0,8'd6,0, 0,0,0,0,1,0,3);
      addRow(0,0,8'd6,0, 0,0,0,0,0,1,3);
      addRow(0,0,8'd6,0, 0,0,0,0,0,0,3);
      // Abort during LOAD suppresses load/prod_clr.
      addRow(1,0,8'd6,0, 0,0,0,0,0,0,3);
      addRow(1,1,8'd6,0, 0,0,0,0,1,0,3);
      addRow(0,0,8'd6,0, 0,0,0,0,0,0,0);

      rstN  = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      #12;
      checkOutput("reset", outVec, 10'b0);
      @(negedge clk);
      rstN = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("row%0d", i), outVec, vecs[i].exp);
      end

      // Asynchronous reset between edges while in RUN.
      @(negedge clk);
      start   = 1'b1;
      operand = 8'd6;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("preResetRun", outVec, {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,4'd0});
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("asyncReset", outVec, 10'b0);
      #1;
      rstN = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("postResetIdle", outVec, 10'b0);
      @(negedge clk);
      #1;
      checkOutput("postResetLoad", outVec, {1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,4'd0});
      start = 1'b0;

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
